addr_map_engine: RTL and testbench

- Parametrised successor of the fixed-mapper SNES address decoder. A table of NUM_REGIONS programmable regions replaces the hard-coded HiROM/LoROM/ExHiROM/BS-X/menu equations.
- The MCU loads the regions at runtime through a shadow/commit register port.
- Per cycle, the block matches SNES_ADDR against the active table and produces a registered ROM_ADDR plus IS_ROM/IS_SAVERAM/IS_WRITABLE.
- It also produces per-region qualified hit strobes for peripherals, generalising the msu/dspx shift-register debounce.

---
 rtl/addr_map_pkg.sv | 29 ++
 rtl/addr_map_qual.sv | 44 ++++
 rtl/addr_map_engine.sv | 180 ++++++++++++++++++
 tb/tb_addr_map_engine.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/addr_map_pkg.sv
// Shared definitions for the programmable SNES address map: config field codes,
// flag bit positions and the region table record.
package addr_map_pkg;

   // Width of every address-valued field in the region record.
   localparam int unsigned MAP_ADDR_W = 24;

   localparam logic [2:0] FLD_MATCH_VAL  = 3'd0;
   localparam logic [2:0] FLD_MATCH_MASK = 3'd1;
   localparam logic [2:0] FLD_BASE       = 3'd2;
   localparam logic [2:0] FLD_XMASK      = 3'd3;
   localparam logic [2:0] FLD_TARGET     = 3'd4;
   localparam logic [2:0] FLD_FLAGS      = 3'd5;

   localparam int unsigned FLG_EN   = 0;
   localparam int unsigned FLG_SRAM = 1;
   localparam int unsigned FLG_WR   = 2;
   localparam int unsigned FLG_QUAL = 3;

   typedef struct packed {
      logic [MAP_ADDR_W-1:0] match_val;
      logic [MAP_ADDR_W-1:0] match_mask;
      logic [MAP_ADDR_W-1:0] base;
      logic [MAP_ADDR_W-1:0] xmask;
      logic [MAP_ADDR_W-1:0] target;
      logic [3:0]            flags;
   } region_t;

endpackage

// File: rtl/addr_map_qual.sv
// Per-region hit qualifier: saturating run-length counter of consecutive wins,
// with a registered "counter at threshold" output.
module addr_map_qual #(
   parameter int unsigned QUAL_CYCLES = 4
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic en,
   input  logic win,
   input  logic clr,
   input  logic flush,
   output logic hit_qual
);

   localparam logic [3:0] QMax = 4'(QUAL_CYCLES);

   logic [3:0] qc_q, qc_d;
   logic       hit_q, hit_d;

   // clr restarts qualification only; flush also drops the output at once.
   always_comb begin
      qc_d  = '0;
      hit_d = 1'b0;
      if (en && !flush) begin
         hit_d = (qc_q == QMax);
         if (win && !clr) begin
            qc_d = (qc_q == QMax) ? qc_q : qc_q + 4'd1;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         qc_q  <= '0;
         hit_q <= 1'b0;
      end else begin
         qc_q  <= qc_d;
         hit_q <= hit_d;
      end
   end

   assign hit_qual = hit_q;

endmodule

// File: rtl/addr_map_engine.sv
// Programmable SNES address decoder: shadow/active region table, priority match,
// base/mask/target translation and per-region debounced hit strobes.
module addr_map_engine
   import addr_map_pkg::*;
#(
   parameter int unsigned NUM_REGIONS = 8,
   parameter int unsigned ADDR_W      = MAP_ADDR_W,
   parameter int unsigned IDX_W       = 3,
   parameter int unsigned QUAL_CYCLES = 4
) (
   input  logic                   CLK,
   input  logic                   RST_N,
   input  logic [ADDR_W-1:0]      SNES_ADDR,
   input  logic                   MCU_OVR,
   input  logic [ADDR_W-1:0]      MCU_ADDR,
   input  logic                   CFG_WE,
   input  logic [IDX_W-1:0]       CFG_IDX,
   input  logic [2:0]             CFG_FIELD,
   input  logic [ADDR_W-1:0]      CFG_DATA,
   input  logic                   CFG_COMMIT,
   output logic [ADDR_W-1:0]      ROM_ADDR,
   output logic                   IS_ROM,
   output logic                   IS_SAVERAM,
   output logic                   IS_WRITABLE,
   output logic [IDX_W-1:0]       HIT_IDX,
   output logic                   MISS,
   output logic [NUM_REGIONS-1:0] HIT_QUAL
);

   region_t shadow_q [NUM_REGIONS];
   region_t active_q [NUM_REGIONS];

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int r = 0; r < NUM_REGIONS; r++) begin
            shadow_q[r] <= '0;
         end
      end else if (CFG_WE) begin
         // Out-of-range indices match no entry, so such writes fall away.
         for (int r = 0; r < NUM_REGIONS; r++) begin
            if (CFG_IDX == IDX_W'(r)) begin
               case (CFG_FIELD)
                  FLD_MATCH_VAL:  shadow_q[r].match_val  <= MAP_ADDR_W'(CFG_DATA);
                  FLD_MATCH_MASK: shadow_q[r].match_mask <= MAP_ADDR_W'(CFG_DATA);
                  FLD_BASE:       shadow_q[r].base       <= MAP_ADDR_W'(CFG_DATA);
                  FLD_XMASK:      shadow_q[r].xmask      <= MAP_ADDR_W'(CFG_DATA);
                  FLD_TARGET:     shadow_q[r].target     <= MAP_ADDR_W'(CFG_DATA);
                  FLD_FLAGS:      shadow_q[r].flags      <= CFG_DATA[3:0];
                  default: ;
               endcase
            end
         end
      end
   end

   // Commit samples shadow before any same-edge write lands.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int r = 0; r < NUM_REGIONS; r++) begin
            active_q[r] <= '0;
         end
      end else if (CFG_COMMIT) begin
         for (int r = 0; r < NUM_REGIONS; r++) begin
            active_q[r] <= shadow_q[r];
         end
      end
   end

   logic [NUM_REGIONS-1:0] match;
   logic                   win_hit;
   logic [IDX_W-1:0]       win_idx;
   logic [ADDR_W-1:0]      win_target, win_base, win_xmask;
   logic                   win_sram, win_wr;

   always_comb begin
      for (int r = 0; r < NUM_REGIONS; r++) begin
         match[r] = active_q[r].flags[FLG_EN] &&
                    ((SNES_ADDR & ADDR_W'(active_q[r].match_mask)) ==
                     ADDR_W'(active_q[r].match_val));
      end
   end

   // Scan high to low so the lowest matching index is the last one kept.
   always_comb begin
      win_hit    = 1'b0;
      win_idx    = '0;
      win_target = '0;
      win_base   = '0;
      win_xmask  = '0;
      win_sram   = 1'b0;
      win_wr     = 1'b0;
      for (int r = int'(NUM_REGIONS) - 1; r >= 0; r--) begin
         if (match[r]) begin
            win_hit    = 1'b1;
            win_idx    = IDX_W'(r);
            win_target = ADDR_W'(active_q[r].target);
            win_base   = ADDR_W'(active_q[r].base);
            win_xmask  = ADDR_W'(active_q[r].xmask);
            win_sram   = active_q[r].flags[FLG_SRAM];
            win_wr     = active_q[r].flags[FLG_WR];
         end
      end
   end

   logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
   logic [IDX_W-1:0]  hit_idx_q, hit_idx_d;
   logic              is_rom_q, is_rom_d;
   logic              is_sram_q, is_sram_d;
   logic              is_wr_q, is_wr_d;
   logic              miss_q, miss_d;

   always_comb begin
      rom_addr_d = SNES_ADDR;
      hit_idx_d  = '0;
      is_rom_d   = 1'b0;
      is_sram_d  = 1'b0;
      is_wr_d    = 1'b0;
      miss_d     = 1'b1;
      if (!MCU_OVR) begin
         rom_addr_d = MCU_ADDR;
      end else if (win_hit) begin
         rom_addr_d = win_target + ((SNES_ADDR - win_base) & win_xmask);
         hit_idx_d  = win_idx;
         is_rom_d   = !win_sram;
         is_sram_d  = win_sram;
         is_wr_d    = win_wr;
         miss_d     = 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rom_addr_q <= '0;
         hit_idx_q  <= '0;
         is_rom_q   <= 1'b0;
         is_sram_q  <= 1'b0;
         is_wr_q    <= 1'b0;
         miss_q     <= 1'b1;
      end else begin
         rom_addr_q <= rom_addr_d;
         hit_idx_q  <= hit_idx_d;
         is_rom_q   <= is_rom_d;
         is_sram_q  <= is_sram_d;
         is_wr_q    <= is_wr_d;
         miss_q     <= miss_d;
      end
   end

   assign ROM_ADDR    = rom_addr_q;
   assign HIT_IDX     = hit_idx_q;
   assign IS_ROM      = is_rom_q;
   assign IS_SAVERAM  = is_sram_q;
   assign IS_WRITABLE = is_wr_q;
   assign MISS        = miss_q;

   logic [NUM_REGIONS-1:0] win_vec;
   logic [NUM_REGIONS-1:0] changed;

   always_comb begin
      for (int r = 0; r < NUM_REGIONS; r++) begin
         win_vec[r] = MCU_OVR && win_hit && (win_idx == IDX_W'(r));
         changed[r] = CFG_COMMIT && (shadow_q[r] != active_q[r]);
      end
   end

   for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_qual
      addr_map_qual #(
         .QUAL_CYCLES(QUAL_CYCLES)
      ) u_qual (
         .CLK     (CLK),
         .RST_N   (RST_N),
         .en      (active_q[g].flags[FLG_QUAL]),
         .win     (win_vec[g]),
         .clr     (changed[g]),
         .flush   (!MCU_OVR),
         .hit_qual(HIT_QUAL[g])
      );
   end

endmodule

// File: tb/tb_addr_map_engine.sv
// Directed bench for addr_map_engine: stimulus queues expected responses, a
// negedge monitor pops and compares them against the registered outputs.
module tb_addr_map_engine;
   import addr_map_pkg::*;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic [23:0] SNES_ADDR;
   logic        MCU_OVR;
   logic [23:0] MCU_ADDR;
   logic        CFG_WE;
   logic [2:0]  CFG_IDX;
   logic [2:0]  CFG_FIELD;
   logic [23:0] CFG_DATA;
   logic        CFG_COMMIT;
   logic [23:0] ROM_ADDR;
   logic        IS_ROM, IS_SAVERAM, IS_WRITABLE, MISS;
   logic [2:0]  HIT_IDX;
   logic [7:0]  HIT_QUAL;

   addr_map_engine dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .SNES_ADDR  (SNES_ADDR),
      .MCU_OVR    (MCU_OVR),
      .MCU_ADDR   (MCU_ADDR),
      .CFG_WE     (CFG_WE),
      .CFG_IDX    (CFG_IDX),
      .CFG_FIELD  (CFG_FIELD),
      .CFG_DATA   (CFG_DATA),
      .CFG_COMMIT (CFG_COMMIT),
      .ROM_ADDR   (ROM_ADDR),
      .IS_ROM     (IS_ROM),
      .IS_SAVERAM (IS_SAVERAM),
      .IS_WRITABLE(IS_WRITABLE),
      .HIT_IDX    (HIT_IDX),
      .MISS       (MISS),
      .HIT_QUAL   (HIT_QUAL)
   );

   always #5 CLK = ~CLK;

   int unsigned cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      int unsigned ecyc;
      bit          dec;
      bit [23:0]   rom;
      bit [2:0]    idx;
      bit          isrom, issram, iswr, miss;
      bit          qual;
      bit [7:0]    hq;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];
   int    n_chk = 0;
   int    n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      n_chk++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, want, $time);
      end
   endtask

   // Expectations apply to outputs after the next active edge.
   task automatic exp_dec(input string nm, input logic [23:0] rom, input logic [2:0] idx,
                          input bit isrom, input bit issram, input bit iswr, input bit miss);
      exp_t e;
      e.ecyc = cyc + 1; e.dec = 1'b1; e.qual = 1'b0; e.hq = '0;
      e.rom = rom; e.idx = idx; e.isrom = isrom; e.issram = issram; e.iswr = iswr;
      e.miss = miss;
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   task automatic exp_hq(input string nm, input logic [7:0] hq);
      exp_t e;
      e.ecyc = cyc + 1; e.dec = 1'b0; e.qual = 1'b1; e.hq = hq;
      e.rom = '0; e.idx = '0; e.isrom = 1'b0; e.issram = 1'b0; e.iswr = 1'b0; e.miss = 1'b0;
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   exp_t  mon_e;
   string mon_n;
   always @(negedge CLK) begin
      while (exp_q.size() != 0 && exp_q[0].ecyc <= cyc) begin
         mon_e = exp_q.pop_front();
         mon_n = name_q.pop_front();
         if (mon_e.dec) begin
            chk({mon_n, ".rom"},    32'(ROM_ADDR),    32'(mon_e.rom));
            chk({mon_n, ".idx"},    32'(HIT_IDX),     32'(mon_e.idx));
            chk({mon_n, ".is_rom"}, 32'(IS_ROM),      32'(mon_e.isrom));
            chk({mon_n, ".is_sr"},  32'(IS_SAVERAM),  32'(mon_e.issram));
            chk({mon_n, ".is_wr"},  32'(IS_WRITABLE), 32'(mon_e.iswr));
            chk({mon_n, ".miss"},   32'(MISS),        32'(mon_e.miss));
         end
         if (mon_e.qual) chk({mon_n, ".hq"}, 32'(HIT_QUAL), 32'(mon_e.hq));
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic cfg_wr(input logic [2:0] idx, input logic [2:0] fld, input logic [23:0] data);
      CFG_IDX = idx; CFG_FIELD = fld; CFG_DATA = data; CFG_WE = 1'b1;
      tick();
      CFG_WE = 1'b0;
   endtask

   task automatic prog(input logic [2:0] idx, input logic [23:0] mv, input logic [23:0] mm,
                       input logic [23:0] base, input logic [23:0] xm, input logic [23:0] tgt,
                       input logic [23:0] flg);
      cfg_wr(idx, FLD_MATCH_VAL, mv);
      cfg_wr(idx, FLD_MATCH_MASK, mm);
      cfg_wr(idx, FLD_BASE, base);
      cfg_wr(idx, FLD_XMASK, xm);
      cfg_wr(idx, FLD_TARGET, tgt);
      cfg_wr(idx, FLD_FLAGS, flg);
   endtask

   task automatic commit();
      CFG_COMMIT = 1'b1;
      tick();
      CFG_COMMIT = 1'b0;
   endtask

   task automatic chk_reset(input string nm);
      chk({nm, ".rom"},  32'(ROM_ADDR), 32'h0);
      chk({nm, ".idx"},  32'(HIT_IDX),  32'h0);
      chk({nm, ".is"},   32'({IS_ROM, IS_SAVERAM, IS_WRITABLE}), 32'h0);
      chk({nm, ".miss"}, 32'(MISS),     32'h1);
      chk({nm, ".hq"},   32'(HIT_QUAL), 32'h0);
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
      chk("drain", 32'(exp_q.size()), 32'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      RST_N = 1'b0; SNES_ADDR = '0; MCU_OVR = 1'b1; MCU_ADDR = '0;
      CFG_WE = 1'b0; CFG_IDX = '0; CFG_FIELD = '0; CFG_DATA = '0; CFG_COMMIT = 1'b0;
      #12;
      chk_reset("reset");
      tick();
      RST_N = 1'b1;

      // Empty table: pass-through miss
      SNES_ADDR = 24'hC01234;
      exp_dec("miss_empty", 24'hC01234, 3'd0, 0, 0, 0, 1);
      exp_hq("miss_empty", 8'h00);
      tick();

      // r0 save-RAM window
      prog(3'd0, 24'h706000, 24'h70E000, 24'h706000, 24'h001FFF, 24'hE00000, 24'h7);
      commit();
      SNES_ADDR = 24'h307FFF;
      exp_dec("r0_bank30_miss", 24'h307FFF, 3'd0, 0, 0, 0, 1);
      tick();
      SNES_ADDR = 24'h707FFF;
      exp_dec("r0_sram", 24'hE01FFF, 3'd0, 0, 1, 1, 0);
      tick();

      // r1 HiROM catch-all; r0 keeps priority on overlap
      prog(3'd1, 24'h400000, 24'h400000, 24'h000000, 24'h3FFFFF, 24'h000000, 24'h1);
      commit();
      SNES_ADDR = 24'h706000;
      exp_dec("prio_r0", 24'hE00000, 3'd0, 0, 1, 1, 0);
      tick();
      SNES_ADDR = 24'hC01234;
      exp_dec("r1_hirom", 24'h001234, 3'd1, 1, 0, 0, 0);
      tick();

      // r2 qualified region: held 6 cycles then left
      prog(3'd2, 24'h002000, 24'h40FFF8, 24'h000000, 24'h000000, 24'h000000, 24'h9);
      commit();
      SNES_ADDR = 24'h002003;
      exp_dec("r2_dec", 24'h000000, 3'd2, 1, 0, 0, 0);
      for (int i = 0; i < 6; i++) begin
         exp_hq($sformatf("qual_hold%0d", i), (i >= 4) ? 8'h04 : 8'h00);
         tick();
      end
      SNES_ADDR = 24'h008000;
      exp_dec("r2_leave", 24'h008000, 3'd0, 0, 0, 0, 1);
      exp_hq("qual_leave1", 8'h04);
      tick();
      exp_hq("qual_leave2", 8'h00);
      tick();

      // 3-cycle pulse never qualifies
      for (int i = 0; i < 6; i++) begin
         SNES_ADDR = (i < 3) ? 24'h002003 : 24'h008000;
         exp_hq($sformatf("pulse%0d", i), 8'h00);
         tick();
      end

      // Shadow write without commit has no effect
      cfg_wr(3'd0, FLD_TARGET, 24'h100000);
      SNES_ADDR = 24'h707FFF;
      exp_dec("shadow_only", 24'hE01FFF, 3'd0, 0, 1, 1, 0);
      tick();

      // Write and commit together: commit takes pre-write shadow (TARGET=0x100000)
      CFG_IDX = 3'd0; CFG_FIELD = FLD_TARGET; CFG_DATA = 24'h200000;
      CFG_WE = 1'b1; CFG_COMMIT = 1'b1;
      tick();
      CFG_WE = 1'b0; CFG_COMMIT = 1'b0;
      exp_dec("wr_commit_old", 24'h101FFF, 3'd0, 0, 1, 1, 0);
      tick();
      commit();
      exp_dec("wr_commit_new", 24'h201FFF, 3'd0, 0, 1, 1, 0);
      tick();

      // MCU override during a qualified hit
      SNES_ADDR = 24'h002003;
      for (int i = 0; i < 5; i++) begin
         exp_hq($sformatf("mcu_pre%0d", i), (i == 4) ? 8'h04 : 8'h00);
         tick();
      end
      MCU_OVR = 1'b0; MCU_ADDR = 24'hABCDEF;
      exp_dec("mcu_ovr", 24'hABCDEF, 3'd0, 0, 0, 0, 1);
      exp_hq("mcu_ovr", 8'h00);
      tick();
      MCU_OVR = 1'b1;
      exp_dec("mcu_back", 24'h000000, 3'd2, 1, 0, 0, 0);
      exp_hq("mcu_back", 8'h00);
      tick();

      // Async reset mid-stream
      SNES_ADDR = 24'h707FFF;
      exp_dec("pre_reset", 24'h201FFF, 3'd0, 0, 1, 1, 0);
      tick();
      drain();
      #2;
      RST_N = 1'b0;
      #1;
      chk_reset("async_reset");
      tick();
      RST_N = 1'b1;
      exp_dec("post_reset_cleared", 24'h707FFF, 3'd0, 0, 0, 0, 1);
      tick();
      drain();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
